multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM that sequences the shared-memory multicycle MIPS datapath: one memory port, one ALU, PC/IR/A/B/ALUOut regs.
//  Replaces the single-cycle main decoder.
//  Issues per-state datapath strobes, waits on a variable-latency memory handshake and traps illegal opcodes and memory timeouts.
//  Feeds alu_op to the existing ALU decoder.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles a state waits for mem_ready before trapping (1..255)
// PORTS
//  clk          in   1  sole clock; all state updates on rising edge
//  reset_n      in   1  synchronous, active-low reset
//  op_code      in   6  IR[31:26]; sampled in DECODE only
//  alu_zero     in   1  ALU zero flag; used in BRANCH only
//  mem_ready    in   1  memory completes current access this cycle
//  mem_req      out  1  memory access request; held until mem_ready
//  i_or_d       out  1  0 = address from PC, 1 = from ALUOut
//  mem_write    out  1  write strobe to memory (qualified by mem_req)
//  ir_write     out  1  load IR
//  pc_write     out  1  load PC (unconditional or taken branch)
//  reg_dst      out  1  0 = rt, 1 = rd
//  mem_to_reg   out  1  0 = ALUOut, 1 = data reg
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0 = PC, 1 = A
//  alu_src_b    out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
//  alu_op       out  2  00 = add, 01 = sub, 10 = decode funct
//  pc_src       out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
//  trap         out  1  sticky; FSM in ERROR
//  trap_cause   out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
// BEHAVIOUR
//  - Reset: reset_n low at an edge -> state = FETCH, timer = 0, trap = 0, trap_cause = 00.
//  - While reset_n is low, every strobe output is forced to 0; mux selects are 0.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ERROR.
//  - FETCH: mem_req = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00.
//    While mem_ready = 0, stay and keep ir_write = pc_write = 0.
//    On mem_ready: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
//  - DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by op_code:
//    000000 -> EXEC
//    100011 / 101011 -> MEMADR
//    000100 -> BRANCH
//    001000 -> ADDIEX
//    000010 -> JUMP
//    any other -> ERROR, cause 01
//  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: mem_req = 1, i_or_d = 1. On mem_ready -> MEMWB.
//  - MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
//  - MEMWR: mem_req = 1, i_or_d = 1, mem_write = 1. On mem_ready -> FETCH.
//  - EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> ALUWB.
//  - ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
//  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_write = alu_zero. -> FETCH.
//  - ADDIEX: as MEMADR. -> ADDIWB.
//  - ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
//  - JUMP: pc_src = 10, pc_write = 1. -> FETCH.
//  - ERROR: all strobes 0, trap = 1. Absorbing; exit only via reset.
//  - Opcode latch: op_code is latched at the DECODE edge. MEMADR and ADDIEX use the latched copy, not the live input.
//  - Wait timer (8 bit):
//    - Cleared on every state change.
//    - Increments each cycle spent in FETCH / MEMRD / MEMWR with mem_ready = 0.
//    - If the timer reaches MEM_TIMEOUT with mem_ready still 0 -> ERROR, cause 10.
//    - mem_ready on the same cycle the timer reaches MEM_TIMEOUT wins: normal transition, no trap.
//  - Latency (zero-wait memory):
//    - R-type / addi / lw: 4 / 4 / 5 cycles.
//    - sw / beq / j: 4 / 3 / 3 cycles.
//  - Reset mid-access: FSM returns to FETCH; the in-flight memory access is abandoned, with no mem_write pulse on the reset cycle.
// CONFIGURATION
//  BNE_SUPPORT_EN
//  - Defined: op_code 000101 -> BRANCH, with pc_write = ~alu_zero for this opcode (beq keeps alu_zero).
//  - Undefined: 000101 is illegal -> ERROR, cause 01.
// TESTING
//  1. Hold reset_n = 0 for 2 cycles, mem_ready = 1 -> after release: FETCH, trap = 0, all strobes 0 during reset.
//  2. add (000000), mem_ready = 1 -> 4 cycles.
//     - pc_write high in cycle 1.
//     - Cycle 4: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
//  3. lw with mem_ready low 3 cycles in MEMRD -> state held; MEMWB 1 cycle after mem_ready; 8 cycles total.
//  4. beq: alu_zero = 1 -> pc_write = 1, pc_src = 01 in BRANCH; alu_zero = 0 -> pc_write = 0.
//  5. op_code 111111 -> ERROR after DECODE, trap_cause = 01, sticky until reset_n low.
//  6. MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> ERROR on 5th cycle, trap_cause = 10.
//     Repeat with mem_ready = 1 on the 4th wait cycle -> no trap.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath/memory.
//   Datapath -> controller : op_code[5:0], alu_zero, mem_ready
//   Controller -> datapath : mem_req, i_or_d, mem_write, ir_write, pc_write,
//                            reg_dst, mem_to_reg, reg_write, alu_src_a,
//                            alu_src_b[1:0], alu_op[1:0], pc_src[1:0]
//   Controller status      : trap, trap_cause[1:0]
// The controller attaches through the master modport; the datapath/memory
// side (or a testbench standing in for it) uses the slave modport.
interface multicycle_controller_if;
  logic [5:0] op_code;
  logic       alu_zero;
  logic       mem_ready;

  logic       mem_req;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  op_code, alu_zero, mem_ready,
    output mem_req, i_or_d, mem_write, ir_write, pc_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_src, trap, trap_cause
  );

  modport slave (
    output op_code, alu_zero, mem_ready,
    input  mem_req, i_or_d, mem_write, ir_write, pc_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_src, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for the shared-memory multicycle MIPS datapath.
// Drives per-state datapath strobes, waits on a variable-latency memory
// handshake and traps on illegal opcodes or memory timeouts.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset_n  - synchronous, active-low reset
//   bus      - multicycle_controller_if.master (opcode/flags in, strobes out)
// Parameters:
//   MEM_TIMEOUT - cycles a memory-wait state tolerates mem_ready low (1..255)
// Build option:
//   BNE_SUPPORT_EN - when defined, opcode 000101 (bne) branches on ~alu_zero;
//                    otherwise it is treated as an illegal opcode.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned TIMER_W = 8;
  localparam int unsigned CNT_W   = TIMER_W + 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_ERROR
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   w_next_timer;
  logic [5:0]           r_op;
  logic [1:0]           r_trap_cause;
  logic [1:0]           w_next_cause;
  logic                 w_wait_state;
  logic                 w_timeout;

  logic                 w_mem_req;
  logic                 w_i_or_d;
  logic                 w_mem_write;
  logic                 w_ir_write;
  logic                 w_pc_write;
  logic                 w_reg_dst;
  logic                 w_mem_to_reg;
  logic                 w_reg_write;
  logic                 w_alu_src_a;
  logic [1:0]           w_alu_src_b;
  logic [1:0]           w_alu_op;
  logic [1:0]           w_pc_src;

  // States that wait on the memory handshake and run the timeout timer.
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);

  // Fires on the cycle the timer would reach MEM_TIMEOUT without mem_ready;
  // a mem_ready on that same cycle takes priority in the state logic.
  assign w_timeout = w_wait_state && !bus.mem_ready &&
                     (({1'b0, r_timer} + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT));

  // State, timer, trap cause and opcode latch registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_timer      <= '0;
      r_trap_cause <= CAUSE_NONE;
      r_op         <= '0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_next_timer;
      r_trap_cause <= w_next_cause;
      if (r_state == S_DECODE) begin
        r_op <= bus.op_code;
      end
    end
  end

  // Next-state and per-state strobe decode.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_trap_cause;
    w_mem_req    = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;

    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed while the instruction word is fetched.
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        // Speculative branch target into ALUOut.
        w_alu_src_b = 2'b11;
        case (bus.op_code)
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_BEQ:       w_next_state = S_BRANCH;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       w_next_state = S_BRANCH;
`endif
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default: begin
            w_next_state = S_ERROR;
            w_next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_next_state = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = S_MEMWB;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end

      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = S_FETCH;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
          w_next_cause = CAUSE_TIMEOUT;
        end
      end

      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b10;
        w_next_state = S_ALUWB;
      end

      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
`ifdef BNE_SUPPORT_EN
        w_pc_write  = (r_op == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
`else
        w_pc_write  = bus.alu_zero;
`endif
        w_next_state = S_FETCH;
      end

      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_write   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_ERROR: begin
        w_next_state = S_ERROR;
      end

      default: begin
        w_next_state = S_ERROR;
      end
    endcase
  end

  // Wait timer: restarts on any state change, counts stalled wait cycles.
  always_comb begin
    if (w_next_state != r_state) begin
      w_next_timer = '0;
    end else if (w_wait_state && !bus.mem_ready) begin
      w_next_timer = r_timer + TIMER_W'(1);
    end else begin
      w_next_timer = r_timer;
    end
  end

  // Outputs are gated by reset_n so nothing strobes (e.g. a mem_write of an
  // abandoned store) during a reset cycle.
  assign bus.mem_req    = reset_n & w_mem_req;
  assign bus.i_or_d     = reset_n & w_i_or_d;
  assign bus.mem_write  = reset_n & w_mem_write;
  assign bus.ir_write   = reset_n & w_ir_write;
  assign bus.pc_write   = reset_n & w_pc_write;
  assign bus.reg_dst    = reset_n & w_reg_dst;
  assign bus.mem_to_reg = reset_n & w_mem_to_reg;
  assign bus.reg_write  = reset_n & w_reg_write;
  assign bus.alu_src_a  = reset_n & w_alu_src_a;
  assign bus.alu_src_b  = reset_n ? w_alu_src_b : 2'b00;
  assign bus.alu_op     = reset_n ? w_alu_op : 2'b00;
  assign bus.pc_src     = reset_n ? w_pc_src : 2'b00;
  assign bus.trap       = reset_n & (r_state == S_ERROR);
  assign bus.trap_cause = reset_n ? r_trap_cause : CAUSE_NONE;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// A phase-level model expands each instruction into its expected per-cycle
// control vector (with random memory stalls and random don't-care inputs),
// then each test replays the queue cycle by cycle against the DUT.
module tb_multicycle_controller;

  localparam int TB_TIMEOUT = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [17:0] exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [17:0] obs;
  int          errors = 0;
  int          checks = 0;
  cyc_t        q[$];

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign obs = {bus.mem_req, bus.i_or_d, bus.mem_write, bus.ir_write,
                bus.pc_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.trap, bus.trap_cause};

  // ---------------- expected control vectors per phase ----------------
  function automatic logic [17:0] ev(
    input logic req, iod, mw, irw, pcw, rdst, m2r, rw, sa,
    input logic [1:0] sb, aop, psrc,
    input logic trp,
    input logic [1:0] cause);
    return {req, iod, mw, irw, pcw, rdst, m2r, rw, sa, sb, aop, psrc, trp, cause};
  endfunction

  function automatic logic [17:0] v_fetch(input logic done);
    return ev(1, 0, 0, done, done, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_dec();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_addr();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_memrd();
    return ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_memwb();
    return ev(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_memwr();
    return ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_exec();
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_aluwb();
    return ev(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_branch(input logic pcw);
    return ev(0, 0, 0, 0, pcw, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_addiwb();
    return ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_jump();
    return ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 2'b00);
  endfunction
  function automatic logic [17:0] v_err(input logic [1:0] cause);
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, cause);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic void push(input logic rst_n, input logic rdy, input logic zero,
                               input logic [5:0] op, input logic [17:0] exp);
    cyc_t c;
    c.rst_n = rst_n; c.rdy = rdy; c.zero = zero; c.op = op; c.exp = exp;
    q.push_back(c);
  endfunction

  function automatic void push_reset(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b1, rb(), rop(), 18'd0);
  endfunction

  function automatic void push_error(input logic [1:0] cause, input int n);
    for (int k = 0; k < n; k++) push(1'b1, rb(), rb(), rop(), v_err(cause));
  endfunction

  // Memory access with 'stall' not-ready cycles; returns 1 if it times out
  // (the timer reaches TB_TIMEOUT after TB_TIMEOUT stalled cycles).
  function automatic bit wait_phase(input int stall, input logic [17:0] v_wait,
                                    input logic [17:0] v_done);
    int n;
    n = (stall >= TB_TIMEOUT) ? TB_TIMEOUT : stall;
    for (int k = 0; k < n; k++) push(1'b1, 1'b0, rb(), rop(), v_wait);
    if (stall >= TB_TIMEOUT) return 1'b1;
    push(1'b1, 1'b1, rb(), rop(), v_done);
    return 1'b0;
  endfunction

  // Expands one instruction; returns the trap cause it ends in (00 = none).
  function automatic logic [1:0] model_instr(input logic [5:0] op, input int fs,
                                             input int ms, input logic zero);
    if (wait_phase(fs, v_fetch(1'b0), v_fetch(1'b1))) return 2'b10;
    push(1'b1, rb(), rb(), op, v_dec());
    case (op)
      OP_R: begin
        push(1'b1, rb(), rb(), rop(), v_exec());
        push(1'b1, rb(), rb(), rop(), v_aluwb());
      end
      OP_LW: begin
        push(1'b1, rb(), rb(), rop(), v_addr());
        if (wait_phase(ms, v_memrd(), v_memrd())) return 2'b10;
        push(1'b1, rb(), rb(), rop(), v_memwb());
      end
      OP_SW: begin
        push(1'b1, rb(), rb(), rop(), v_addr());
        if (wait_phase(ms, v_memwr(), v_memwr())) return 2'b10;
      end
      OP_BEQ: push(1'b1, rb(), zero, rop(), v_branch(zero));
`ifdef BNE_SUPPORT_EN
      OP_BNE: push(1'b1, rb(), zero, rop(), v_branch(~zero));
`endif
      OP_ADDI: begin
        push(1'b1, rb(), rb(), rop(), v_addr());
        push(1'b1, rb(), rb(), rop(), v_addiwb());
      end
      OP_J: push(1'b1, rb(), rb(), rop(), v_jump());
      default: return 2'b01;
    endcase
    return 2'b00;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input cyc_t c, output logic [17:0] o);
    reset_n       = c.rst_n;
    bus.mem_ready = c.rdy;
    bus.alu_zero  = c.zero;
    bus.op_code   = c.op;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(2);
    void'(model_instr(OP_J, 0, 0, 1'b0));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL reset cyc=%0d rst_n=%b got=%h exp=%h", n, c.rst_n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_rtype();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(1);
    void'(model_instr(OP_R, 0, 0, rb()));
    void'(model_instr(OP_R, 0, 0, rb()));
    void'(model_instr(OP_ADDI, 0, 0, rb()));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL rtype cyc=%0d op=%b got=%h exp=%h", n, c.op, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_lw_stall();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(1);
    void'(model_instr(OP_LW, 0, 3, rb()));
    void'(model_instr(OP_SW, 1, 2, rb()));
    void'(model_instr(OP_LW, 2, 0, rb()));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL lw_stall cyc=%0d rdy=%b got=%h exp=%h", n, c.rdy, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    logic [17:0] o;
    logic [1:0] cause;
    int n = 0;
    push_reset(1);
    void'(model_instr(OP_BEQ, 0, 0, 1'b1));
    void'(model_instr(OP_BEQ, 0, 0, 1'b0));
    cause = model_instr(OP_BNE, 0, 0, 1'b0);
    if (cause != 2'b00) push_error(cause, 2);
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL branch cyc=%0d zero=%b got=%h exp=%h", n, c.zero, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(1);
    push_error(model_instr(OP_BAD, 0, 0, 1'b0), 5);
    push_reset(1);
    void'(model_instr(OP_J, 0, 0, 1'b0));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(1);
    push_error(model_instr(OP_R, TB_TIMEOUT, 0, 1'b0), 3);
    push_reset(1);
    void'(model_instr(OP_R, TB_TIMEOUT - 1, 0, 1'b0));
    push_error(model_instr(OP_SW, 0, TB_TIMEOUT, 1'b0), 2);
    push_reset(1);
    void'(model_instr(OP_LW, 0, TB_TIMEOUT - 1, 1'b0));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL timeout cyc=%0d rdy=%b got=%h exp=%h", n, c.rdy, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    logic [17:0] o;
    int n = 0;
    push_reset(1);
    push(1'b1, 1'b1, rb(), rop(), v_fetch(1'b1));
    push(1'b1, rb(), rb(), OP_SW, v_dec());
    push(1'b1, rb(), rb(), rop(), v_addr());
    push(1'b1, 1'b0, rb(), rop(), v_memwr());
    push(1'b0, 1'b0, rb(), rop(), 18'd0);
    void'(model_instr(OP_J, 0, 0, 1'b0));
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d rst_n=%b got=%h exp=%h", n, c.rst_n, o, c.exp);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    logic [17:0] o;
    logic [5:0] op;
    logic [1:0] cause;
    int fs;
    int ms;
    int n = 0;
    push_reset(1);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        6: op = OP_BNE;
        7: op = OP_LW;
        default: op = rop();
      endcase
      fs = ($urandom_range(0, 9) == 0) ? TB_TIMEOUT : int'($urandom_range(0, TB_TIMEOUT - 1));
      ms = ($urandom_range(0, 9) == 0) ? TB_TIMEOUT : int'($urandom_range(0, TB_TIMEOUT - 1));
      cause = model_instr(op, fs, ms, rb());
      if (cause != 2'b00) begin
        push_error(cause, 2);
        push_reset(1);
      end
    end
    while (q.size() != 0) begin
      c = q.pop_front();
      apply(c, o);
      checks++;
      if (o !== c.exp) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d op=%b rdy=%b got=%h exp=%h",
                 n, c.op, c.rdy, o, c.exp);
      end
      n++;
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.alu_zero  = 1'b0;
    bus.op_code   = 6'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
